// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Multi-cycle, width-parametrised datapath ALU for the calculator
//            core. Logic and add/sub ops complete in one cycle after start.
//            Unsigned multiply (shift-add) and divide (restoring) iterate one
//            bit per cycle. Result and flags are registered and held until the
//            next completion.
// Ports    : clk, reset (sync, active-high), start, control[2:0],
//            inA/inB[WIDTH-1:0] -> busy, done, out[WIDTH-1:0], zero,
//            negative, overflow, and hi[WIDTH-1:0] when ALU_HI_EN is defined
// Options  : ALU_HI_EN - exposes the upper product half / remainder on `hi`
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       control,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             negative,
`ifdef ALU_HI_EN
    output logic             overflow,
    output logic [WIDTH-1:0] hi
`else
    output logic             overflow
`endif
);

    localparam int       c_msb    = WIDTH - 1;
    localparam logic [2:0] c_op_mul = 3'd0;
    localparam logic [2:0] c_op_div = 3'd1;
    localparam logic [2:0] c_op_add = 3'd2;
    localparam logic [2:0] c_op_sub = 3'd3;
    localparam logic [2:0] c_op_and = 3'd4;
    localparam logic [2:0] c_op_or  = 3'd5;
    localparam logic [2:0] c_op_nor = 3'd6;
    localparam logic [2:0] c_op_xor = 3'd7;

    typedef enum logic [1:0] {
        c_st_idle = 2'd0,
        c_st_iter = 2'd1,
        c_st_fin  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b, r_acc, r_q, r_out;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_zero, r_neg, r_ovf;

    logic             w_fast, w_load;
    logic [WIDTH:0]   w_sum, w_shift, w_diff;
    logic [WIDTH-1:0] w_acc_nxt, w_q_nxt, w_res;
    logic             w_res_ovf;

    // Divide by zero bypasses the iteration and completes like a logic op.
    assign w_fast = ((control != c_op_mul) && (control != c_op_div)) ||
                    ((control == c_op_div) && (inB == '0));

    // Result registers load on the edge that enters FIN, so out/flags are
    // already valid during the cycle in which done is high.
    assign w_load = (w_state_nxt == c_st_fin);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt = w_fast ? c_st_fin : c_st_iter;
                end
            end
            c_st_iter: begin
                busy = 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = c_st_fin;
                end
            end
            c_st_fin: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------ iteration step
    // {r_acc, r_q} is the double-width working register. MUL: r_q holds the
    // multiplier and shifts right as product bits arrive from the adder.
    // DIV: r_q holds the dividend, shifts left into the partial remainder in
    // r_acc, and collects quotient bits in its LSB.
    always_comb begin
        w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_a} : '0);
        w_shift = {r_acc, r_q[c_msb]};
        w_diff  = w_shift - {1'b0, r_b};
        if (r_op == c_op_mul) begin
            w_acc_nxt = w_sum[WIDTH:1];
            w_q_nxt   = {w_sum[0], r_q[c_msb:1]};
        end else if (!w_diff[WIDTH]) begin
            // Partial remainder stays below the divisor, so a clear MSB on
            // the difference reliably means "divisor fits".
            w_acc_nxt = w_diff[c_msb:0];
            w_q_nxt   = {r_q[c_msb-1:0], 1'b1};
        end else begin
            w_acc_nxt = w_shift[c_msb:0];
            w_q_nxt   = {r_q[c_msb-1:0], 1'b0};
        end
    end

    // ------------------------------------------------------ result select
    // In IDLE the result comes straight from the ports (single-cycle ops and
    // divide by zero); otherwise it is the final iteration step.
    always_comb begin
        w_res     = '0;
        w_res_ovf = 1'b0;
        if (r_state == c_st_idle) begin
            case (control)
                c_op_add: begin
                    w_res     = inA + inB;
                    w_res_ovf = (inA[c_msb] == inB[c_msb]) && (w_res[c_msb] != inA[c_msb]);
                end
                c_op_sub: begin
                    w_res     = inA - inB;
                    w_res_ovf = (inA[c_msb] != inB[c_msb]) && (w_res[c_msb] != inA[c_msb]);
                end
                c_op_and: w_res = inA & inB;
                c_op_or:  w_res = inA | inB;
                c_op_nor: w_res = ~(inA | inB);
                c_op_xor: w_res = inA ^ inB;
                // Only divide by zero reaches FIN from here among MUL/DIV.
                default: begin
                    w_res     = '1;
                    w_res_ovf = 1'b1;
                end
            endcase
        end else begin
            w_res     = w_q_nxt;
            w_res_ovf = (r_op == c_op_mul) && (w_acc_nxt != '0);
        end
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= '0;
            r_acc  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_out  <= '0;
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if ((r_state == c_st_idle) && start) begin
                r_a   <= inA;
                r_b   <= inB;
                r_op  <= control;
                r_acc <= '0;
                r_q   <= (control == c_op_mul) ? inB : inA;
                r_cnt <= CNT_W'(WIDTH);
            end else if (r_state == c_st_iter) begin
                r_acc <= w_acc_nxt;
                r_q   <= w_q_nxt;
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_load) begin
                r_out  <= w_res;
                r_zero <= (w_res == '0);
                r_neg  <= w_res[c_msb];
                r_ovf  <= w_res_ovf;
            end
        end
    end

    assign out      = r_out;
    assign zero     = r_zero;
    assign negative = r_neg;
    assign overflow = r_ovf;

`ifdef ALU_HI_EN
    logic [WIDTH-1:0] w_res_hi, r_hi;

    always_comb begin
        w_res_hi = '0;
        if (r_state == c_st_idle) begin
            // Divide by zero reports the dividend as remainder.
            if (control == c_op_div) begin
                w_res_hi = inA;
            end
        end else begin
            w_res_hi = w_acc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
        end else if (w_load) begin
            r_hi <= w_res_hi;
        end
    end

    assign hi = r_hi;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Purpose  : Self-checking bench for alu_mc (WIDTH=32). Table of vectors run
//            back-to-back, plus hand sequences for ignored start and reset
//            during an operation. Expected results go to a scoreboard queue
//            when start is driven and are checked when done is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

    localparam int W = 32;
    localparam logic [2:0] MUL = 3'd0, DIV = 3'd1, ADD = 3'd2, SUB = 3'd3;
    localparam logic [2:0] AND_ = 3'd4, OR_ = 3'd5, NOR_ = 3'd6, XOR_ = 3'd7;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [2:0]   control;
    logic [W-1:0] inA, inB, out;
    logic         busy, done, zero, negative, overflow;
`ifdef ALU_HI_EN
    logic [W-1:0] hi;
`endif

    alu_mc #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .control  (control),
        .inA      (inA),
        .inB      (inB),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .zero     (zero),
        .negative (negative),
`ifdef ALU_HI_EN
        .overflow (overflow),
        .hi       (hi)
`else
        .overflow (overflow)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b, out, hi;
        logic         zero, neg, ovf;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] out, hi;
        logic         zero, neg, ovf;
        int           cyc;
    } exp_t;

    vec_t vecs[16];
    exp_t sb[$];
    exp_t m_e;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] o, input logic [W-1:0] h,
                                input logic z, input logic n, input logic v, input int lat);
        vec_t r;
        r.op = op; r.a = a; r.b = b; r.out = o; r.hi = h;
        r.zero = z; r.neg = n; r.ovf = v; r.lat = lat;
        return r;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest request.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no pending result (cycle %0d)", cyc);
            end else begin
                m_e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(m_e.cyc));
                chk("out", 64'(out), 64'(m_e.out));
                chk("zero", 64'(zero), 64'(m_e.zero));
                chk("negative", 64'(negative), 64'(m_e.neg));
                chk("overflow", 64'(overflow), 64'(m_e.ovf));
`ifdef ALU_HI_EN
                chk("hi", 64'(hi), 64'(m_e.hi));
`endif
            end
        end
    end

    // Called at a negedge; drives one start cycle and queues the expectation.
    task automatic issue(input vec_t v);
        exp_t e;
        control = v.op; inA = v.a; inB = v.b; start = 1'b1;
        e.out = v.out; e.hi = v.hi; e.zero = v.zero; e.neg = v.neg; e.ovf = v.ovf;
        e.cyc = cyc + v.lat;
        sb.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        inA     = $urandom;
        inB     = $urandom;
        control = 3'($urandom);
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 100 && !done; k++) @(negedge clk);
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got no done, expected done within 100 cycles", name);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        vecs[0]  = mk(ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        1'b0, 1'b1, 1'b1, 1);
        vecs[1]  = mk(SUB,  32'd5,        32'd5,        32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1);
        vecs[2]  = mk(NOR_, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h0,        1'b0, 1'b1, 1'b0, 1);
        vecs[3]  = mk(MUL,  32'h00010000, 32'h00010000, 32'h00000000, 32'h1,        1'b1, 1'b0, 1'b1, 33);
        vecs[4]  = mk(DIV,  32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 1'b0, 33);
        vecs[5]  = mk(DIV,  32'd9,        32'd0,        32'hFFFFFFFF, 32'd9,        1'b0, 1'b1, 1'b1, 1);
        vecs[6]  = mk(AND_, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0,        1'b0, 1'b0, 1'b0, 1);
        vecs[7]  = mk(OR_,  32'h12340000, 32'h00005678, 32'h12345678, 32'h0,        1'b0, 1'b0, 1'b0, 1);
        vecs[8]  = mk(XOR_, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 32'h0,        1'b0, 1'b0, 1'b0, 1);
        vecs[9]  = mk(SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0,        1'b0, 1'b0, 1'b1, 1);
        vecs[10] = mk(ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 1);
        vecs[11] = mk(MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 33);
        vecs[12] = mk(MUL,  32'h00012345, 32'h00000100, 32'h01234500, 32'h0,        1'b0, 1'b0, 1'b0, 33);
        vecs[13] = mk(DIV,  32'hFFFFFFFF, 32'd10,       32'h19999999, 32'd5,        1'b0, 1'b0, 1'b0, 33);
        vecs[14] = mk(DIV,  32'd3,        32'd7,        32'd0,        32'd3,        1'b1, 1'b0, 1'b0, 33);
        vecs[15] = mk(SUB,  32'h0,        32'h1,        32'hFFFFFFFF, 32'h0,        1'b0, 1'b1, 1'b0, 1);

        reset = 1'b1; start = 1'b0; control = 3'd0; inA = '0; inB = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_flags", 64'({zero, negative, overflow}), 64'd0);
`ifdef ALU_HI_EN
        chk("rst_hi", 64'(hi), 64'd0);
`endif
        reset = 1'b0;

        // Table vectors, each started in the cycle right after the previous done.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("idle_busy", 64'(busy), 64'd0);
            issue(vecs[i]);
            chk("busy_after_start", 64'(busy), 64'd1);
            wait_done("vec");
        end

        // Second start during MUL must be ignored.
        @(negedge clk);
        t0 = cyc;
        issue(mk(MUL, 32'd3, 32'd5, 32'd15, 32'd0, 1'b0, 1'b0, 1'b0, 33));
        while (cyc < t0 + 5) @(negedge clk);
        control = ADD; inA = 32'd1; inB = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignored_start", 64'(busy), 64'd1);
        wait_done("mul_ignore");
        repeat (3) @(negedge clk);
        chk("idle_after_mul", 64'(busy), 64'd0);

        // Reset during DIV: abort, no done, everything cleared.
        t0 = cyc;
        control = DIV; inA = 32'd100; inB = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_out", 64'(out), 64'd0);
        chk("abort_flags", 64'({zero, negative, overflow}), 64'd0);
        reset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) chk("abort_no_done", 64'(done), 64'd0);
        end
        issue(mk(ADD, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1));
        wait_done("add_after_abort");
        repeat (3) @(negedge clk);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
